pixel_blend_pipe: RTL and testbench

PIXEL_BLEND_PIPE -- requirements
Module: pixel_blend_pipe

---
 rtl/pixel_blend_pipe_pkg.sv | 26 ++
 rtl/pixel_blend_pipe_blend_mult.sv | 30 +++
 rtl/pixel_blend_pipe.sv | 177 +++++++++++++++++
 tb/tb_pixel_blend_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_blend_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_blend_pipe_pkg
// Brief    : Shared defaults and mode constants for the pixel blend pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_blend_pipe_pkg;

  // Default parameter values
  localparam int c_def_pix_w      = 8;
  localparam int c_def_ch         = 3;
  localparam int c_def_w_w        = 8;
  localparam int c_def_frame_pix  = 270000;
  localparam int c_def_trunc_bits = 0;

  // Sum post-processing modes (value of sat_en)
  localparam logic c_mode_wrap = 1'b0;
  localparam logic c_mode_sat  = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_blend_pipe_blend_mult.sv
`default_nettype none
// ============================================================================
// Module   : blend_mult
// Brief    : Combinational pixel x weight multiplier; the TRUNC_BITS LSBs of
//            the pixel are forced to zero before the multiply.
// Revision : 1.0 - initial release
// ============================================================================
module blend_mult
  import pixel_blend_pipe_pkg::*;
#(
  parameter int PIX_W      = c_def_pix_w,
  parameter int W_W        = c_def_w_w,
  parameter int TRUNC_BITS = c_def_trunc_bits
) (
  input  logic [PIX_W-1:0]     pix,
  input  logic [W_W-1:0]       w,
  output logic [PIX_W+W_W-1:0] prod
);

  localparam int                c_prod_w = PIX_W + W_W;
  localparam logic [PIX_W-1:0]  c_keep   = {PIX_W{1'b1}} << TRUNC_BITS;

  logic [PIX_W-1:0] w_pix_m;

  // Drop the low pixel bits in approximate mode, then form the full product
  assign w_pix_m = pix & c_keep;
  assign prod    = c_prod_w'(w_pix_m) * c_prod_w'(w);

endmodule
`default_nettype wire

// File: rtl/pixel_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pixel_blend_pipe
// Brief    : Two-stage weighted blend of two pixel streams with per-frame
//            weight latching, saturate/wrap selection and frame-end marking.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_blend_pipe
  import pixel_blend_pipe_pkg::*;
#(
  parameter int PIX_W      = c_def_pix_w,
  parameter int CH         = c_def_ch,
  parameter int W_W        = c_def_w_w,
  parameter int FRAME_PIX  = c_def_frame_pix,
  parameter int TRUNC_BITS = c_def_trunc_bits
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*PIX_W-1:0] in_a,
  input  logic [CH*PIX_W-1:0] in_b,
  input  logic [W_W-1:0]      wa,
  input  logic [W_W-1:0]      wb,
  input  logic                sat_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*PIX_W-1:0] out_pix,
  output logic                out_last
);

  localparam int                c_prod_w = PIX_W + W_W;
  localparam int                c_cnt_w  = cnt_width(FRAME_PIX);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FRAME_PIX - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  // Handshake
  logic w_stall;
  logic w_accept;
  logic w_xfer;

  // Frame bookkeeping
  logic [c_cnt_w-1:0] r_in_cnt;
  logic [c_cnt_w-1:0] r_out_cnt;
  logic               w_first;
  logic [W_W-1:0]     r_wa_l;
  logic [W_W-1:0]     r_wb_l;
  logic               r_sat_l;
  logic [W_W-1:0]     w_wa_cur;
  logic [W_W-1:0]     w_wb_cur;
  logic               w_sat_cur;

  // Stage 1: products
  logic [c_prod_w-1:0] w_prod_a [CH];
  logic [c_prod_w-1:0] w_prod_b [CH];
  logic [c_prod_w-1:0] r_prod_a [CH];
  logic [c_prod_w-1:0] r_prod_b [CH];
  logic                r_s1_valid;
  logic                r_s1_sat;

  // Stage 2: blended pixel
  logic [CH*PIX_W-1:0] w_blend;
  logic                r_out_valid;
  logic [CH*PIX_W-1:0] r_out_pix;

  // An occupied output that is not being taken freezes the whole pipe
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;
  assign w_xfer   = r_out_valid && out_ready;

  // The first beat of a frame uses the live weights; later beats the latched ones
  assign w_first   = (r_in_cnt == '0);
  assign w_wa_cur  = w_first ? wa     : r_wa_l;
  assign w_wb_cur  = w_first ? wb     : r_wb_l;
  assign w_sat_cur = w_first ? sat_en : r_sat_l;

  generate
    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
      logic [PIX_W:0] w_sum;

      blend_mult #(
        .PIX_W      (PIX_W),
        .W_W        (W_W),
        .TRUNC_BITS (TRUNC_BITS)
      ) u_mult_a (
        .pix  (in_a[ch*PIX_W +: PIX_W]),
        .w    (w_wa_cur),
        .prod (w_prod_a[ch])
      );

      blend_mult #(
        .PIX_W      (PIX_W),
        .W_W        (W_W),
        .TRUNC_BITS (TRUNC_BITS)
      ) u_mult_b (
        .pix  (in_b[ch*PIX_W +: PIX_W]),
        .w    (w_wb_cur),
        .prod (w_prod_b[ch])
      );

      // Each product is scaled down by 2^W_W on its own before the add
      assign w_sum = {1'b0, r_prod_a[ch][c_prod_w-1 -: PIX_W]}
                   + {1'b0, r_prod_b[ch][c_prod_w-1 -: PIX_W]};

      assign w_blend[ch*PIX_W +: PIX_W] =
        ((r_s1_sat == c_mode_sat) && w_sum[PIX_W]) ? {PIX_W{1'b1}}
                                                   : w_sum[PIX_W-1:0];
    end
  endgenerate

  // Input beat counter and per-frame weight/mode capture on the first accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt <= '0;
      r_wa_l   <= '0;
      r_wb_l   <= '0;
      r_sat_l  <= c_mode_wrap;
    end else if (w_accept) begin
      r_in_cnt <= (r_in_cnt == c_last) ? '0 : r_in_cnt + c_one;
      if (w_first) begin
        r_wa_l  <= wa;
        r_wb_l  <= wb;
        r_sat_l <= sat_en;
      end
    end
  end

  // Stage 1: register the products together with the beat's own mode bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sat   <= c_mode_wrap;
      for (int i = 0; i < CH; i++) begin
        r_prod_a[i] <= '0;
        r_prod_b[i] <= '0;
      end
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sat <= w_sat_cur;
        for (int i = 0; i < CH; i++) begin
          r_prod_a[i] <= w_prod_a[i];
          r_prod_b[i] <= w_prod_b[i];
        end
      end
    end
  end

  // Stage 2: register the summed / saturated pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_pix <= w_blend;
      end
    end
  end

  // Output beat counter advances on each completed transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (w_xfer) begin
      r_out_cnt <= (r_out_cnt == c_last) ? '0 : r_out_cnt + c_one;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_last  = r_out_valid && (r_out_cnt == c_last);

endmodule
`default_nettype wire

// File: tb/tb_pixel_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_blend_pipe
// Brief    : Self-checking bench: exact and approximate (TRUNC_BITS=4)
//            instances with 4-pixel frames checked against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_blend_pipe;

  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sat_en;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [7:0]  wa;
  logic [7:0]  wb;

  logic        in_ready,   out_valid,   out_last;
  logic [23:0] out_pix;
  logic        in_ready_t, out_valid_t, out_last_t;
  logic [23:0] out_pix_t;

  always #5 clk = ~clk;

  pixel_blend_pipe #(
    .PIX_W(8), .CH(3), .W_W(8), .FRAME_PIX(FP), .TRUNC_BITS(0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .wa(wa), .wb(wb), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_last(out_last)
  );

  pixel_blend_pipe #(
    .PIX_W(8), .CH(3), .W_W(8), .FRAME_PIX(FP), .TRUNC_BITS(4)
  ) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_a(in_a), .in_b(in_b), .wa(wa), .wb(wb), .sat_en(sat_en),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_pix(out_pix_t),
    .out_last(out_last_t)
  );

  typedef struct {
    logic [23:0] pix;
    logic [23:0] pix_t;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          last_pos[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_in_idx = 0;
  int          xfer_cnt = 0;
  logic [7:0]  m_wa = 8'h00;
  logic [7:0]  m_wb = 8'h00;
  logic        m_sat = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_pix = 24'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: per channel, mask, scale each product by 1/256, add, clamp or wrap
  function automatic logic [23:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic [7:0] xa, input logic [7:0] xb,
                                        input logic s, input int trunc);
    logic [23:0] r;
    int ac, bc, sm;
    r = 24'h0;
    for (int c = 0; c < 3; c++) begin
      ac = int'(a[8*c +: 8]) & ~((1 << trunc) - 1);
      bc = int'(b[8*c +: 8]) & ~((1 << trunc) - 1);
      sm = (ac * int'(xa)) / 256 + (bc * int'(xb)) / 256;
      if (s && sm > 255) sm = 255;
      r[8*c +: 8] = sm[7:0];
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, check outputs / record accepts, advance
  task automatic drive(input logic v, input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] xa, input logic [7:0] xb,
                       input logic s, input logic ordy);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; wa = xa; wb = xb; sat_en = s; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      xfer_cnt++;
      if (out_last) last_pos.push_back(xfer_cnt);
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_pix",     {8'h0, out_pix},   {8'h0, e.pix});
        chk("out_pix_t",   {8'h0, out_pix_t}, {8'h0, e.pix_t});
        chk("out_last",    {31'h0, out_last},   {31'h0, e.last});
        chk("out_last_t",  {31'h0, out_last_t}, {31'h0, e.last});
        chk("out_valid_t", {31'h0, out_valid_t}, 32'd1);
      end
    end
    if (out_valid && !out_ready) begin
      chk("stall_in_ready",   {31'h0, in_ready},   32'd0);
      chk("stall_in_ready_t", {31'h0, in_ready_t}, 32'd0);
      if (prev_stall) chk("stall_hold_pix", {8'h0, out_pix}, {8'h0, prev_pix});
    end else begin
      chk("in_ready", {31'h0, in_ready}, 32'd1);
    end
    prev_stall = out_valid && !out_ready;
    prev_pix   = out_pix;
    if (in_valid && in_ready) begin
      if (m_in_idx == 0) begin
        m_wa = xa; m_wb = xb; m_sat = s;
      end
      e.pix   = model(a, b, m_wa, m_wb, m_sat, 0);
      e.pix_t = model(a, b, m_wa, m_wb, m_sat, 4);
      e.last  = (m_in_idx == FP - 1);
      q.push_back(e);
      m_in_idx = (m_in_idx + 1) % FP;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic v);
    rst = 1'b1; in_valid = v; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'h0, out_last},  32'd0);
    chk("rst_out_pix",   {8'h0, out_pix},    32'd0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'd1);
    repeat (n - 1) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    q.delete(); last_pos.delete();
    m_in_idx = 0; xfer_cnt = 0; prev_stall = 1'b0;
    m_wa = 8'h00; m_wb = 8'h00; m_sat = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_empty", q.size(), 32'd0);
    drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_en = 1'b0;
    in_a = 24'h0; in_b = 24'h0; wa = 8'h0; wb = 8'h0;
    @(negedge clk);
    do_reset(2, 1'b0);

    // Mid-grey blend: result two cycles after accept
    drive(1'b1, 24'h404040, 24'h808080, 8'h80, 8'h80, 1'b1, 1'b1);
    chk("lat_cycle1_valid", {31'h0, out_valid}, 32'd0);
    drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("lat_cycle2_valid", {31'h0, out_valid}, 32'd1);
    chk("grey_pix", {8'h0, out_pix}, 32'h00606060);
    drain();

    // Full-scale inputs: saturate vs wrap (mode is latched per frame)
    do_reset(1, 1'b0);
    drive(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("sat_pix", {8'h0, out_pix}, 32'h00FFFFFF);
    drain();
    do_reset(1, 1'b0);
    drive(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("wrap_pix", {8'h0, out_pix}, 32'h00FCFCFC);
    drain();

    // Approximate mode: low nibble dropped before multiply
    do_reset(1, 1'b0);
    drive(1'b1, 24'h1F1F1F, 24'h5A5A5A, 8'hFF, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 24'h0, 24'h0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("trunc_pix",       {8'h0, out_pix_t}, 32'h000F0F0F);
    chk("trunc_exact_pix", {8'h0, out_pix},   32'h001E1E1E);
    drain();

    // Two back-to-back frames, wa changed after the first beat
    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 24'($urandom), 24'($urandom), (i == 0) ? 8'h30 : 8'hC0, 8'h50, 1'b0, 1'b1);
    end
    drain();
    chk("frames_last_count", last_pos.size(), 32'd2);
    if (last_pos.size() == 2) begin
      chk("frames_last_pos0", last_pos[0], 32'd4);
      chk("frames_last_pos1", last_pos[1], 32'd8);
    end

    // Five-cycle downstream stall mid-stream
    do_reset(1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            !(i >= 4 && i < 9));
    end
    drain();

    // Reset on the third beat of a frame discards it; next frame restarts at 0
    do_reset(1, 1'b0);
    drive(1'b1, 24'($urandom), 24'($urandom), 8'h40, 8'h40, 1'b1, 1'b1);
    drive(1'b1, 24'($urandom), 24'($urandom), 8'h40, 8'h40, 1'b1, 1'b1);
    do_reset(1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 24'($urandom), 24'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    end
    drain();
    chk("rst_frame_last_count", last_pos.size(), 32'd1);
    if (last_pos.size() == 1) chk("rst_frame_last_pos", last_pos[0], 32'd4);

    // Random traffic with bubbles and back-pressure
    do_reset(1, 1'b0);
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 24'($urandom), 24'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
